// File: rtl/alu_seq_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq_hs : registered handshake ALU with shift-add multiplier.         |
// | Define ALU_SAT_EN for signed-saturating ADD/SUB.  Rev 1.0                |
// +--------------------------------------------------------------------------+
module alu_seq_hs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = CNT_W - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  // S_EXEC is the single compute cycle that gives non-MUL ops their one-clock latency.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_MUL_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [WIDTH-1:0]     out_hi_q, out_hi_d;
  logic [3:0]           flags_q, flags_d;

  logic [WIDTH:0]       add_w;
  logic [WIDTH:0]       sub_w;
  logic [WIDTH:0]       shl_w;
  logic [SH_W-1:0]      sh_amt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;
  logic [WIDTH:0]       mul_upper;

`ifdef ALU_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  always_comb begin
    add_w   = {1'b0, a_q} + {1'b0, b_q};
    sub_w   = {1'b0, a_q} - {1'b0, b_q};
    sh_amt  = b_q[SH_W-1:0];
    // Bit WIDTH of the widened shift holds the last bit pushed out of the result.
    shl_w   = {1'b0, a_q} << sh_amt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin
        if ({1'b0, sh_amt} < CNT_W'(WIDTH)) begin
          alu_res = shl_w[WIDTH-1:0];
          alu_c   = (sh_amt != '0) && shl_w[WIDTH];
        end
      end
      default: alu_res = '0;
    endcase
`ifdef ALU_SAT_EN
    // Overflow direction follows the sign of a for both ADD and SUB.
    if (alu_v) begin
      alu_res = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_hi_d  = out_hi_q;
    flags_d   = flags_q;
    mul_upper = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = select;
          prod_d  = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = (select == OP_MUL) ? S_MUL_RUN : S_EXEC;
        end
      end
      S_EXEC: begin
        out_d    = alu_res;
        out_hi_d = '0;
        flags_d  = {alu_res[WIDTH-1], alu_v, alu_c, (alu_res == '0)};
        state_d  = S_DONE;
      end
      S_MUL_RUN: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          out_d    = prod_q[WIDTH-1:0];
          out_hi_d = prod_q[2*WIDTH-1:WIDTH];
          flags_d  = {prod_q[2*WIDTH-1], 1'b0, (prod_q[2*WIDTH-1:WIDTH] != '0), (prod_q == '0)};
          state_d  = S_DONE;
        end else begin
          // Multiplier bits leave from the bottom as the partial sum enters at the top.
          prod_d = {mul_upper, prod_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign flags     = flags_q;

endmodule
`default_nettype wire
